// File: rtl/x_gclk_ctrl_pkg.sv
// Shared definitions for the gated-clock controller: FSM state encoding
// and the width of the wake-settle counter.
package x_gclk_ctrl_pkg;

    typedef enum logic [1:0] {
        X_GCLK_RUN   = 2'd0,
        X_GCLK_IDLE  = 2'd1,
        X_GCLK_GATED = 2'd2,
        X_GCLK_WAKE  = 2'd3
    } x_gclk_state_e;

    // Holds WAKE_CYC values 1..15.
    localparam int X_GCLK_WCNT_W = 4;

endpackage

// File: rtl/x_gclk_en_q.sv
// Falling-edge enable register for an AND-type clock gate; the enable only
// changes while CP is low, so the gated clock cannot glitch.
module x_gclk_en_q (
    input  logic CP,
    input  logic CD,
    input  logic i_d,
    output logic o_q
);

    logic r_q;

    // Capture the enable on the falling edge; reset forces the clock on.
    always_ff @(negedge CP or negedge CD) begin
        if (!CD) begin
            r_q <= 1'b1;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/x_gclk_ctrl.sv
// Gated-clock controller: auto-gates a domain after an idle period and serves
// a 4-phase stop_req/stop_ack handshake. Optional macro X_GCLK_STAT_EN adds a
// saturating counter of cycles spent gated (gated_cnt, cleared by cnt_clr).
module x_gclk_ctrl
    import x_gclk_ctrl_pkg::*;
#(
    parameter int IDLE_W    = 8,
    parameter int WAKE_CYC  = 2,
    parameter int SYNC_EN_Q = 1
) (
    input  logic              CP,
    input  logic              CD,
    input  logic              busy,
    input  logic              wake,
    input  logic [IDLE_W-1:0] idle_thr,
    input  logic              stop_req,
`ifdef X_GCLK_STAT_EN
    input  logic              cnt_clr,
    output logic [31:0]       gated_cnt,
`endif
    output logic              stop_ack,
    output logic              clk_en,
    output logic              wake_done,
    output logic              gated
);

    localparam logic [IDLE_W-1:0]        IDLE_ZERO = {IDLE_W{1'b0}};
    localparam logic [IDLE_W-1:0]        IDLE_ONE  = {{(IDLE_W-1){1'b0}}, 1'b1};
    localparam logic [IDLE_W-1:0]        IDLE_MAX  = {IDLE_W{1'b1}};
    localparam logic [X_GCLK_WCNT_W-1:0] WCNT_ZERO = {X_GCLK_WCNT_W{1'b0}};
    localparam logic [X_GCLK_WCNT_W-1:0] WCNT_ONE  = {{(X_GCLK_WCNT_W-1){1'b0}}, 1'b1};
    localparam logic [X_GCLK_WCNT_W-1:0] WCNT_LAST = X_GCLK_WCNT_W'(WAKE_CYC);

    x_gclk_state_e              r_state;
    x_gclk_state_e              w_next;
    logic [IDLE_W-1:0]          r_idle_cnt;
    logic [IDLE_W-1:0]          w_idle_cnt;
    logic [X_GCLK_WCNT_W-1:0]   r_wake_cnt;
    logic [X_GCLK_WCNT_W-1:0]   w_wake_cnt;
    logic                       r_clk_en, r_ack, r_wake_done, r_gated;
    logic                       w_clk_en, w_ack, w_wake_done, w_gated;

    // State, counters and registered outputs.
    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            r_state     <= X_GCLK_RUN;
            r_idle_cnt  <= IDLE_ZERO;
            r_wake_cnt  <= WCNT_ZERO;
            r_clk_en    <= 1'b1;
            r_ack       <= 1'b0;
            r_wake_done <= 1'b0;
            r_gated     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_idle_cnt  <= w_idle_cnt;
            r_wake_cnt  <= w_wake_cnt;
            r_clk_en    <= w_clk_en;
            r_ack       <= w_ack;
            r_wake_done <= w_wake_done;
            r_gated     <= w_gated;
        end
    end

    // Next-state logic; the idle compare uses >= so a lowered threshold gates at once.
    always_comb begin
        w_next     = r_state;
        w_idle_cnt = r_idle_cnt;
        w_wake_cnt = r_wake_cnt;
        case (r_state)
            X_GCLK_RUN: begin
                if (busy) begin
                    w_next = X_GCLK_RUN;
                end else if (stop_req) begin
                    w_next     = X_GCLK_GATED;
                    w_idle_cnt = IDLE_ZERO;
                end else if (idle_thr != IDLE_ZERO) begin
                    w_next     = X_GCLK_IDLE;
                    w_idle_cnt = IDLE_ONE;
                end else begin
                    w_next = X_GCLK_RUN;
                end
            end
            X_GCLK_IDLE: begin
                if (busy || wake) begin
                    w_next     = X_GCLK_RUN;
                    w_idle_cnt = IDLE_ZERO;
                end else if (stop_req || ((idle_thr != IDLE_ZERO) && (r_idle_cnt >= idle_thr))) begin
                    w_next     = X_GCLK_GATED;
                    w_idle_cnt = IDLE_ZERO;
                end else if (r_idle_cnt != IDLE_MAX) begin
                    w_idle_cnt = r_idle_cnt + IDLE_ONE;
                end else begin
                    w_idle_cnt = IDLE_MAX;
                end
            end
            X_GCLK_GATED: begin
                // A released stop (falling req while acked) wakes just like wake/busy.
                if (wake || busy || (r_ack && !stop_req)) begin
                    w_next     = X_GCLK_WAKE;
                    w_wake_cnt = WCNT_ONE;
                end else begin
                    w_next = X_GCLK_GATED;
                end
            end
            X_GCLK_WAKE: begin
                if (r_wake_cnt >= WCNT_LAST) begin
                    w_next     = X_GCLK_RUN;
                    w_wake_cnt = WCNT_ZERO;
                end else begin
                    w_wake_cnt = r_wake_cnt + WCNT_ONE;
                end
            end
            default: begin
                w_next     = X_GCLK_RUN;
                w_idle_cnt = IDLE_ZERO;
                w_wake_cnt = WCNT_ZERO;
            end
        endcase
    end

    // Output decode from the next state, registered above.
    always_comb begin
        w_gated     = (w_next == X_GCLK_GATED);
        w_clk_en    = !w_gated;
        w_ack       = w_gated && stop_req;
        w_wake_done = (r_state == X_GCLK_WAKE) && (w_next == X_GCLK_RUN);
    end

    assign stop_ack  = r_ack;
    assign wake_done = r_wake_done;
    assign gated     = r_gated;

    generate
        if (SYNC_EN_Q != 0) begin : g_en_q
            logic w_clk_en_q;
            x_gclk_en_q u_en_q (
                .CP  (CP),
                .CD  (CD),
                .i_d (r_clk_en),
                .o_q (w_clk_en_q)
            );
            assign clk_en = w_clk_en_q;
        end else begin : g_en_direct
            assign clk_en = r_clk_en;
        end
    endgenerate

`ifdef X_GCLK_STAT_EN
    logic [31:0] r_gated_cnt;

    // Saturating count of cycles spent gated.
    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            r_gated_cnt <= 32'd0;
        end else if (cnt_clr) begin
            r_gated_cnt <= 32'd0;
        end else if ((r_state == X_GCLK_GATED) && (r_gated_cnt != 32'hFFFF_FFFF)) begin
            r_gated_cnt <= r_gated_cnt + 32'd1;
        end else begin
            r_gated_cnt <= r_gated_cnt;
        end
    end

    assign gated_cnt = r_gated_cnt;
`endif

endmodule
